// File: rtl/divisor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : divisor_pkg                                                  |
// | Description : Shared types and constants for the division scheduler:       |
// |               FSM state encoding, default operand width, counter width.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package divisor_pkg;

  // Default operand width (dividend, divisor, quotient, remainder)
  localparam int DIV_W = 8;

  // Step counter width for the default operand width
  localparam int DIV_CNT_W = $clog2(DIV_W);

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_STEP    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Counter width for an arbitrary operand width; a 1-bit datapath still
  // needs a 1-bit counter to hold the value 0.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : divisor_rr_arb                                               |
// | Description : Combinational NREQ-way round-robin arbiter. Produces a       |
// |               one-hot grant for the first valid requester at or after the  |
// |               priority pointer (wrapping). The pointer register lives in   |
// |               the parent.                                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module divisor_rr_arb #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [PTR_W-1:0] idx;

  // Scan from lowest priority to highest so the highest-priority valid
  // requester (offset 0 from the pointer) is the last one written.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = PTR_W'((int'(ptr) + off) % NREQ);
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/divisor_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : divisor_sched                                                |
// | Description : Sequencer and round-robin arbiter sharing one restoring      |
// |               division datapath among NREQ requesters. Accepts a request,  |
// |               loads the datapath, issues W step pulses, captures quotient  |
// |               and remainder and returns them to the issuing requester.     |
// |               Optional macro DIVISOR_SCHED_ZERO_BYPASS_EN: a zero divisor  |
// |               skips the datapath and answers with q=all ones, r=dividend,  |
// |               rsp_err=1.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module divisor_sched
  import divisor_pkg::*;
#(
  parameter int W    = DIV_W,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_quotient,
  output logic [W-1:0]      rsp_remainder,
  output logic              rsp_err,
  output logic              dp_load,
  output logic              dp_step,
  output logic [W-1:0]      dp_dividend,
  output logic [W-1:0]      dp_divisor,
  input  logic [W-1:0]      dp_quotient,
  input  logic [W-1:0]      dp_remainder
);

  localparam int CNT_W = cnt_width(W);
  localparam int PTR_W = $clog2(NREQ);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] grant_idx;
  logic [NREQ-1:0]  owner_onehot;
  logic [W-1:0]     sel_dividend;
  logic [W-1:0]     sel_divisor;
  logic             accept;

  divisor_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant)
  );

  // Encode the one-hot grant and select the granted requester's operands
  always_comb begin
    grant_idx    = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx    = PTR_W'(i);
        sel_dividend = req_dividend[i*W +: W];
        sel_divisor  = req_divisor[i*W +: W];
      end
    end
  end

  // Decode the recorded owner into its response-valid bit
  always_comb begin
    owner_onehot        = '0;
    owner_onehot[owner] = 1'b1;
  end

  // Grants are only visible while idle; busy requesters simply wait
  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign accept    = (state == ST_IDLE) && (grant != '0);

`ifndef DIVISOR_SCHED_ZERO_BYPASS_EN
  assign rsp_err = 1'b0;
`endif

  // Sequencer: accept, load, W steps, capture, hold response until taken
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      owner         <= '0;
      rr_ptr        <= '0;
      dp_load       <= 1'b0;
      dp_step       <= 1'b0;
      dp_dividend   <= '0;
      dp_divisor    <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
`ifdef DIVISOR_SCHED_ZERO_BYPASS_EN
      rsp_err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dp_dividend <= sel_dividend;
            dp_divisor  <= sel_divisor;
            owner       <= grant_idx;
            rr_ptr      <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef DIVISOR_SCHED_ZERO_BYPASS_EN
            if (sel_divisor == '0) begin
              // Answer directly without touching the datapath
              rsp_valid     <= grant;
              rsp_quotient  <= '1;
              rsp_remainder <= sel_dividend;
              rsp_err       <= 1'b1;
              state         <= ST_RESP;
            end else begin
              dp_load <= 1'b1;
              state   <= ST_LOAD;
            end
`else
            dp_load <= 1'b1;
            state   <= ST_LOAD;
`endif
          end
        end
        ST_LOAD: begin
          dp_load <= 1'b0;
          dp_step <= 1'b1;
          cnt     <= CNT_W'(W - 1);
          state   <= ST_STEP;
        end
        ST_STEP: begin
          // The step issued while cnt is 0 is the W-th and last one
          if (cnt == '0) begin
            dp_step <= 1'b0;
            state   <= ST_CAPTURE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          rsp_quotient  <= dp_quotient;
          rsp_remainder <= dp_remainder;
`ifdef DIVISOR_SCHED_ZERO_BYPASS_EN
          rsp_err       <= 1'b0;
`endif
          rsp_valid     <= owner_onehot;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          dp_load   <= 1'b0;
          dp_step   <= 1'b0;
          rsp_valid <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divisor_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_divisor_sched                                             |
// | Description : Self-checking bench for divisor_sched with a behavioural     |
// |               restoring-division datapath, directed scenarios and a        |
// |               randomized run against an arithmetic reference model.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_divisor_sched;

  localparam int W    = 8;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_dividend;
  logic [NREQ*W-1:0] req_divisor;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_quotient;
  logic [W-1:0]      rsp_remainder;
  logic              rsp_err;
  logic              dp_load;
  logic              dp_step;
  logic [W-1:0]      dp_dividend;
  logic [W-1:0]      dp_divisor;
  logic [W-1:0]      dp_quotient;
  logic [W-1:0]      dp_remainder;

  int n_checks;
  int n_fail;

  divisor_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .dp_load       (dp_load),
    .dp_step       (dp_step),
    .dp_dividend   (dp_dividend),
    .dp_divisor    (dp_divisor),
    .dp_quotient   (dp_quotient),
    .dp_remainder  (dp_remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural restoring divider: shift remainder:quotient left, subtract if it fits
  logic [W-1:0] m_rem = '0;
  logic [W-1:0] m_quo = '0;
  logic [W-1:0] m_dvs = '0;
  wire  [W:0]   m_t  = {m_rem, m_quo[W-1]};
  wire          m_ge = (m_t >= {1'b0, m_dvs});
  assign dp_quotient  = m_quo;
  assign dp_remainder = m_rem;

  always @(posedge clk) begin
    if (dp_load) begin
      m_rem <= '0;
      m_quo <= dp_dividend;
      m_dvs <= dp_divisor;
    end else if (dp_step) begin
      m_rem <= m_ge ? W'(m_t - {1'b0, m_dvs}) : m_t[W-1:0];
      m_quo <= {m_quo[W-2:0], m_ge};
    end
  end

  // Protocol monitor: pulse counts, accept/response timing, invariant violations
  int   loads = 0, steps = 0, viol = 0, acc_n = 0, acc_c = 0, acc_who = 0, rsp_c = 0, rv_cycles = 0;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if ((dp_load && dp_step) || ($countones(req_ready) > 1) || ((req_ready & ~req_valid) != '0)
          || ($countones(rsp_valid) > 1))
        viol <= viol + 1;
      if (dp_load) loads <= loads + 1;
      if (dp_step) steps <= steps + 1;
      if (rsp_valid != '0) rv_cycles <= rv_cycles + 1;
      if ((req_valid & req_ready) != '0) begin
        acc_n   <= acc_n + 1;
        acc_c   <= cyc;
        acc_who <= req_ready[1] ? 1 : 0;
      end
      if ((rsp_valid != '0) && !rv_prev) rsp_c <= cyc;
    end
    rv_prev <= (rsp_valid != '0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) tick();
    rst   = 1'b1;
    viol  = 0;
    loads = 0;
    steps = 0;
  endtask

  task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int n0;
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req_valid[i]           = 1'b1;
    n0 = acc_n;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk); #1;
      if (acc_n != n0) ok = 1'b1;
    end
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_acc(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk); #1;
      if (acc_n >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_rsp(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); #1;
      if (rsp_valid[i]) ok = 1'b1;
    end
  endtask

  task automatic release_rsp(input int i);
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
  endtask

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
    rr_pick = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j = (p + k) % NREQ;
      if (v[j] && rr_pick == '0) rr_pick[j] = 1'b1;
    end
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({req_ready, rsp_valid, dp_load, dp_step, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {req_ready, rsp_valid, dp_load, dp_step, rsp_err});
    end
    n_checks++;
    if ({rsp_quotient, rsp_remainder, dp_dividend, dp_divisor} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {rsp_quotient, rsp_remainder, dp_dividend, dp_divisor});
    end
    req_valid = 2'b11; #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_prio: got %b want 01", req_ready); end
    req_valid = 2'b10; #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b want 10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    bit ok;
    loads = 0; steps = 0;
    send(0, 8'd200, 8'd7, ok);
    n_checks++;
    if (!ok || acc_who != 0) begin n_fail++; $display("FAIL single_accept: got ok=%0d who=%0d want 1/0", ok, acc_who); end
    wait_rsp(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_rsp_timeout: got none want rsp_valid[0]"); end
    n_checks++;
    if (rsp_c - acc_c != 11) begin n_fail++; $display("FAIL single_latency: got %0d want 11", rsp_c - acc_c); end
    n_checks++;
    if (loads != 1 || steps != 8) begin n_fail++; $display("FAIL single_pulses: got load=%0d step=%0d want 1/8", loads, steps); end
    n_checks++;
    if ({rsp_valid, rsp_quotient, rsp_remainder, rsp_err} !== {2'b01, 8'd28, 8'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL single_result: got v=%b q=%0d r=%0d e=%b want 01/28/4/0", rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
    end
    release_rsp(0);
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", rsp_valid); end
  endtask

  task automatic test_arbitration();
    bit ok;
    int n0;
    do_reset();
    req_dividend = {8'd100, 8'd50};
    req_divisor  = {8'd9, 8'd5};
    n0 = acc_n;
    req_valid = 2'b11;
    wait_acc(n0 + 1, ok);
    n_checks++;
    if (!ok || acc_who != 0) begin n_fail++; $display("FAIL arb_first: got ok=%0d who=%0d want 1/0", ok, acc_who); end
    tick();
    req_valid[0] = 1'b0;
    wait_rsp(0, ok);
    n_checks++;
    if (!ok || rsp_quotient !== 8'd10 || rsp_remainder !== 8'd0) begin
      n_fail++; $display("FAIL arb_rsp0: got ok=%0d q=%0d r=%0d want 1/10/0", ok, rsp_quotient, rsp_remainder);
    end
    release_rsp(0);
    wait_acc(n0 + 2, ok);
    n_checks++;
    if (!ok || acc_who != 1) begin n_fail++; $display("FAIL arb_second: got ok=%0d who=%0d want 1/1", ok, acc_who); end
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, ok);
    n_checks++;
    if (!ok || rsp_valid !== 2'b10 || rsp_quotient !== 8'd11 || rsp_remainder !== 8'd1) begin
      n_fail++; $display("FAIL arb_rsp1: got v=%b q=%0d r=%0d want 10/11/1", rsp_valid, rsp_quotient, rsp_remainder);
    end
    release_rsp(1);
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL arb_invariants: got %0d violations want 0", viol); end
  endtask

  task automatic test_stall();
    bit ok;
    int n0;
    send(0, 8'd123, 8'd10, ok);
    req_dividend[W +: W] = 8'd77;
    req_divisor[W +: W]  = 8'd7;
    req_valid[1] = 1'b1;
    wait_rsp(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_rsp_timeout: got none want rsp_valid[0]"); end
    n0 = acc_n;
    for (int k = 0; k < 5; k++) begin
      rsp_ready[1] = k[0];
      @(negedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_quotient, rsp_remainder, req_ready} !== {2'b01, 8'd12, 8'd3, 2'b00}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b q=%0d r=%0d rdy=%b want 01/12/3/00", k, rsp_valid, rsp_quotient, rsp_remainder, req_ready);
      end
    end
    rsp_ready[1] = 1'b0;
    n_checks++;
    if (acc_n != n0) begin n_fail++; $display("FAIL stall_no_accept: got %0d accepts want 0", acc_n - n0); end
    release_rsp(0);
    wait_acc(n0 + 1, ok);
    n_checks++;
    if (!ok || acc_who != 1) begin n_fail++; $display("FAIL stall_next: got ok=%0d who=%0d want 1/1", ok, acc_who); end
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, ok);
    n_checks++;
    if (!ok || rsp_quotient !== 8'd11 || rsp_remainder !== 8'd0) begin
      n_fail++; $display("FAIL stall_rsp1: got ok=%0d q=%0d r=%0d want 1/11/0", ok, rsp_quotient, rsp_remainder);
    end
    release_rsp(1);
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    send(0, 8'd200, 8'd3, ok);
    steps = 0;
    hit   = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (dp_step && steps == 3) hit = 1'b1;
      else tick();
    end
    n_checks++;
    if (!ok || !hit) begin n_fail++; $display("FAIL rstmid_reach: got ok=%0d hit=%0d want 1/1", ok, hit); end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({req_ready, rsp_valid, dp_load, dp_step, rsp_err, rsp_quotient, rsp_remainder, dp_dividend, dp_divisor} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h want 0", {req_ready, rsp_valid, dp_load, dp_step, rsp_err, rsp_quotient, rsp_remainder, dp_dividend, dp_divisor});
    end
    rst = 1'b1;
    steps = 0; loads = 0; rv_cycles = 0;
    repeat (15) tick();
    n_checks++;
    if (steps != 0 || loads != 0 || rv_cycles != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got step=%0d load=%0d rsp=%0d want 0/0/0", steps, loads, rv_cycles);
    end
    send(0, 8'd9, 8'd3, ok);
    wait_rsp(0, ok);
    n_checks++;
    if (!ok || rsp_quotient !== 8'd3 || rsp_remainder !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_after: got ok=%0d q=%0d r=%0d want 1/3/0", ok, rsp_quotient, rsp_remainder);
    end
    release_rsp(0);
  endtask

  task automatic test_zero_div();
    bit ok;
    int exp_lat, exp_loads, exp_steps;
    logic exp_err;
`ifdef DIVISOR_SCHED_ZERO_BYPASS_EN
    exp_lat = 1;  exp_loads = 0; exp_steps = 0; exp_err = 1'b1;
`else
    exp_lat = 11; exp_loads = 1; exp_steps = 8; exp_err = 1'b0;
`endif
    loads = 0; steps = 0;
    send(0, 8'h5A, 8'h00, ok);
    wait_rsp(0, ok);
    n_checks++;
    if (!ok || rsp_c - acc_c != exp_lat) begin n_fail++; $display("FAIL zero_latency: got ok=%0d lat=%0d want 1/%0d", ok, rsp_c - acc_c, exp_lat); end
    n_checks++;
    if (loads != exp_loads || steps != exp_steps) begin
      n_fail++; $display("FAIL zero_pulses: got load=%0d step=%0d want %0d/%0d", loads, steps, exp_loads, exp_steps);
    end
    n_checks++;
    if ({rsp_quotient, rsp_remainder, rsp_err} !== {8'hFF, 8'h5A, exp_err}) begin
      n_fail++; $display("FAIL zero_result: got q=%h r=%h e=%b want ff/5a/%b", rsp_quotient, rsp_remainder, rsp_err, exp_err);
    end
    release_rsp(0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n0;
    int t[4];
    rsp_ready = 2'b11;
    req_dividend[W +: W] = 8'd100;
    req_divisor[W +: W]  = 8'd9;
    req_valid[1] = 1'b1;
    n0 = acc_n;
    for (int j = 0; j < 4; j++) begin
      wait_acc(n0 + j + 1, ok);
      t[j] = acc_c;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b_accept[%0d]: got timeout want accept", j); end
    end
    tick();
    req_valid[1] = 1'b0;
    for (int j = 1; j < 4; j++) begin
      n_checks++;
      if (t[j] - t[j-1] != 12) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 12", j, t[j] - t[j-1]); end
    end
    repeat (20) tick();
    rsp_ready = 2'b00;
    n_checks++;
    if (rsp_quotient !== 8'd11 || rsp_remainder !== 8'd1 || viol != 0) begin
      n_fail++; $display("FAIL b2b_result: got q=%0d r=%0d viol=%0d want 11/1/0", rsp_quotient, rsp_remainder, viol);
    end
  endtask

  task automatic test_random();
    int pend[NREQ];
    int total, done, owner, ptr, acc_at, lat, dropv;
    bit busy;
    logic [W-1:0] ea, eb, exp_q, exp_r;
    logic exp_e;
    logic [NREQ-1:0] exp_ready, exp_rv;
    do_reset();
    total = 0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 12; total += 12; end
    done = 0; busy = 1'b0; owner = 0; ptr = 0; acc_at = 0; lat = 11; dropv = -1;
    exp_q = '0; exp_r = '0; exp_e = 1'b0;
    for (int c = 0; c < 5000 && done < total; c++) begin
      if (dropv >= 0) begin req_valid[dropv] = 1'b0; dropv = -1; end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && pend[i] > 0 && $urandom_range(0, 2) == 0) begin
          req_dividend[i*W +: W] = W'($urandom);
          req_divisor[i*W +: W]  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = NREQ'($urandom);
      @(negedge clk); #1;
      exp_ready = busy ? '0 : rr_pick(req_valid, ptr);
      exp_rv    = (busy && (cyc - acc_at) >= lat) ? NREQ'(1 << owner) : '0;
      n_checks++;
      if (req_ready !== exp_ready || rsp_valid !== exp_rv) begin
        n_fail++; $display("FAIL rand_hs@%0d: got rdy=%b v=%b want %b/%b", cyc, req_ready, rsp_valid, exp_ready, exp_rv);
      end
      if (exp_rv != '0) begin
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_err} !== {exp_q, exp_r, exp_e}) begin
          n_fail++;
          $display("FAIL rand_data@%0d: got q=%h r=%h e=%b want %h/%h/%b", cyc, rsp_quotient, rsp_remainder, rsp_err, exp_q, exp_r, exp_e);
        end
      end
      if (exp_rv != '0 && rsp_ready[owner]) begin
        busy = 1'b0;
        done++;
      end else if (!busy && exp_ready != '0) begin
        for (int k = 0; k < NREQ; k++) if (exp_ready[k]) owner = k;
        ea    = req_dividend[owner*W +: W];
        eb    = req_divisor[owner*W +: W];
        exp_q = (eb == '0) ? '1 : ea / eb;
        exp_r = (eb == '0) ? ea : ea % eb;
`ifdef DIVISOR_SCHED_ZERO_BYPASS_EN
        exp_e = (eb == '0);
        lat   = (eb == '0) ? 1 : 11;
`else
        exp_e = 1'b0;
        lat   = 11;
`endif
        busy   = 1'b1;
        acc_at = cyc;
        ptr    = (owner + 1) % NREQ;
        pend[owner]--;
        dropv  = owner;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    n_checks++;
    if (done != total || viol != 0) begin
      n_fail++; $display("FAIL rand_complete: got done=%0d viol=%0d want %0d/0", done, viol, total);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b0;
    req_valid    = '0;
    rsp_ready    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    test_reset();
    test_single();
    test_arbitration();
    test_stall();
    test_reset_mid();
    test_zero_div();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divisor_sched.md
Name: divisor_sched

Overview:
- Sequencer and round-robin arbiter that shares one restoring-division datapath (the bring-down/compare/add-bit divider) among NREQ requesters.
- Accepts a request via valid/ready, loads the datapath, then issues exactly W step pulses.
- Captures quotient and remainder, then returns them to the requester that issued the operation.
- Sits between client blocks and the divider datapath; it is the only driver of the datapath control inputs.

Parameters:
W  8  operand width (dividend, divisor, quotient, remainder)
NREQ  2  number of requesters (2..4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
req_valid  in  NREQ  per-requester operation request
req_ready  out  NREQ  per-requester grant/accept
req_dividend  in  NREQ*W  packed dividends, requester i at [i*W +: W]
req_divisor  in  NREQ*W  packed divisors, same packing
rsp_valid  out  NREQ  result valid, only the owner's bit set
rsp_ready  in  NREQ  per-requester result accept
rsp_quotient  out  W  registered quotient
rsp_remainder  out  W  registered remainder
rsp_err  out  1  divide-by-zero flag (see Optional Feature)
dp_load  out  1  one-cycle pulse: datapath loads dp_dividend/dp_divisor
dp_step  out  1  one-cycle pulse per division iteration
dp_dividend  out  W  registered operand to datapath
dp_divisor  out  W  registered operand to datapath
dp_quotient  in  W  datapath quotient
dp_remainder  in  W  datapath remainder

Behaviour:
- Reset:
  - rst low at a clock edge forces state IDLE and clears the step counter, owner, rsp_* registers and dp_* operand registers to 0.
  - The round-robin pointer resets so requester 0 has highest priority.
  - Reset mid-operation abandons the operation: no response is issued and there is no dp_step after reset.
- States: IDLE, LOAD, STEP, CAPTURE, RESP.
- IDLE:
  - req_ready is combinational: exactly one bit is set, for the highest-priority requester with req_valid high. All bits are 0 if no requester is valid.
  - On req_valid&req_ready: latch operands into dp_dividend/dp_divisor, record the owner, advance the RR pointer to owner+1 (mod NREQ), go to LOAD.
- LOAD: dp_load=1 for one cycle; counter loaded to W-1; go to STEP.
- STEP: dp_step=1 every cycle; the counter decrements. When the counter reaches 0 and that step is issued, go to CAPTURE. Exactly W dp_step pulses are issued per operation.
- CAPTURE: register dp_quotient and dp_remainder into rsp_quotient and rsp_remainder; go to RESP.
- RESP:
  - rsp_valid[owner]=1, and rsp data is held stable.
  - On rsp_ready[owner]: go to IDLE. The next accept can occur in that IDLE cycle.
  - rsp_ready on non-owner bits is ignored.
- Latency: accept edge at cycle 0, rsp_valid first high at cycle W+3 (11 for W=8).
- Throughput: with rsp_ready tied high, one operation every W+4 cycles.
- req_ready is 0 in every state except IDLE. Requests arriving while busy wait; they are never dropped.
- dp_load and dp_step are never high in the same cycle.
- Outside their own states, dp_load, dp_step and rsp_valid are 0.

Optional Feature:
- Macro: DIVISOR_SCHED_ZERO_BYPASS_EN.
- Defined:
  - An accepted request with divisor==0 goes IDLE→RESP directly; there is no dp_load and no dp_step.
  - Response values: rsp_quotient=all ones, rsp_remainder=dividend, rsp_err=1.
  - rsp_valid is high at cycle 1 after accept.
  - rsp_err is 0 for all nonzero-divisor operations.
- Undefined:
  - The port exists, but rsp_err is constant 0.
  - A zero divisor runs the normal sequence, and whatever the datapath produces is returned.

Decomposition:
- Shared package divisor_pkg holds:
  - the state encoding constants (IDLE..RESP, 3-bit);
  - the default W;
  - the counter width, clog2(W).
- One natural sub-module, divisor_rr_arb: combinational NREQ-way round-robin one-hot grant from req_valid and the pointer; the pointer register stays in divisor_sched.

Test Plan:
- Single op, W=8, behavioural datapath model: requester 0 sends 200/7 → exactly 1 dp_load and 8 dp_step; rsp_valid[0] at cycle 11; q=28, r=4, rsp_err=0.
- Both requesters valid in the same cycle after reset (1 sends 100/9, 0 sends 50/5) → requester 0 served first (q=10,r=0), then requester 1 (q=11,r=1); req_ready never has 2 bits set.
- rsp_ready[0] held low for 5 cycles in RESP → rsp_valid and data stable; no new accept; rsp_ready[1] pulses are ignored.
- rst driven low during the 4th dp_step → next cycle in IDLE; all outputs 0; no rsp_valid; a subsequent 9/3 returns q=3, r=0.
- Divisor 0 (dividend 0x5A):
  - with macro → rsp_valid at cycle 1, q=0xFF, r=0x5A, rsp_err=1, no dp_load/dp_step;
  - without macro → full 8-step sequence and rsp_err=0.
- Back-to-back with rsp_ready tied high, requester 1 continuously valid → accepts spaced exactly 12 cycles apart.
